ee354_det_bareiss: RTL and testbench

EE354_DET_BAREISS -- requirements
Module: ee354_det_bareiss

---
 rtl/ee354_det_pkg.sv | 29 ++
 rtl/ee354_det_bareiss_if.sv | 27 ++
 rtl/ee354_sdiv.sv | 80 ++++++++
 rtl/ee354_det_bareiss.sv | 171 +++++++++++++++++
 tb/tb_ee354_det_bareiss.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ee354_det_pkg.sv
// Shared definitions for the Bareiss determinant engine: state encoding and parameter limits.
package ee354_det_pkg;

    localparam int unsigned N_MIN = 3;
    localparam int unsigned N_MAX = 8;
    localparam int unsigned W_MIN = 2;

    localparam logic [5:0] ST_I     = 6'b000001;
    localparam logic [5:0] ST_LOAD  = 6'b000010;
    localparam logic [5:0] ST_PIVOT = 6'b000100;
    localparam logic [5:0] ST_ELIM  = 6'b001000;
    localparam logic [5:0] ST_DIV   = 6'b010000;
    localparam logic [5:0] ST_DONE  = 6'b100000;

    typedef enum logic [5:0] {
        StI     = ST_I,
        StLoad  = ST_LOAD,
        StPivot = ST_PIVOT,
        StElim  = ST_ELIM,
        StDiv   = ST_DIV,
        StDone  = ST_DONE
    } state_e;

    // Internal width must hold any product of two input elements.
    function automatic bit params_ok(int unsigned n, int unsigned w, int unsigned dw);
        return (n >= N_MIN) && (n <= N_MAX) && (w >= W_MIN) && (dw >= 2 * w);
    endfunction

endpackage

// File: rtl/ee354_det_bareiss_if.sv
// Request/load/result bundle between a host and the determinant engine.
interface ee354_det_bareiss_if #(
    parameter int unsigned W  = 32,
    parameter int unsigned DW = 64
);
    logic                 Start;
    logic                 Ack;
    logic                 In_Valid;
    logic signed [W-1:0]  In_Data;
    logic                 In_Ready;
    logic signed [DW-1:0] Det;
    logic                 Overflow;
    logic                 q_I;
    logic                 q_Load;
    logic                 q_Comp;
    logic                 q_Done;

    modport master (
        output Start, Ack, In_Valid, In_Data,
        input  In_Ready, Det, Overflow, q_I, q_Load, q_Comp, q_Done
    );

    modport slave (
        input  Start, Ack, In_Valid, In_Data,
        output In_Ready, Det, Overflow, q_I, q_Load, q_Comp, q_Done
    );
endinterface

// File: rtl/ee354_sdiv.sv
// Sequential restoring signed divider: 2*DW-bit dividend by DW-bit divisor, fixed 2*DW+1 cycles.
module ee354_sdiv #(
    parameter int unsigned DW = 64
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   i_start,
    input  logic signed [2*DW-1:0] i_dividend,
    input  logic signed [DW-1:0]   i_divisor,
    output logic                   o_busy,
    output logic                   o_done,
    output logic signed [DW-1:0]   o_quotient,
    output logic                   o_overflow
);
    localparam int unsigned CW = $clog2(2 * DW);

    logic [DW-1:0]   r_rem;
    logic [2*DW-1:0] r_q;
    logic [DW-1:0]   r_dvs;
    logic            r_neg;
    logic            r_dz;
    logic            r_busy;
    logic            r_fix;
    logic [CW-1:0]   r_cnt;

    logic [2*DW-1:0] w_dd_mag;
    logic [DW-1:0]   w_dv_mag;
    logic [DW:0]     w_trial;
    logic [DW:0]     w_diff;
    logic            w_ge;

    always_comb begin
        w_dd_mag = i_dividend[2*DW-1] ? -i_dividend : i_dividend;
        w_dv_mag = i_divisor[DW-1] ? -i_divisor : i_divisor;
        w_trial  = {r_rem, r_q[2*DW-1]};
        w_diff   = w_trial - {1'b0, r_dvs};
        w_ge     = (w_trial >= {1'b0, r_dvs});
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_dvs  <= '0;
            r_neg  <= 1'b0;
            r_dz   <= 1'b0;
            r_busy <= 1'b0;
            r_fix  <= 1'b0;
            r_cnt  <= '0;
        end else if (r_busy) begin
            // Quotient bits shift in as dividend bits shift out of r_q.
            r_rem <= w_ge ? w_diff[DW-1:0] : w_trial[DW-1:0];
            r_q   <= {r_q[2*DW-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(2 * DW - 1)) begin
                r_busy <= 1'b0;
                r_fix  <= 1'b1;
            end
        end else if (r_fix) begin
            r_fix <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_q    <= w_dd_mag;
            r_dvs  <= w_dv_mag;
            r_neg  <= i_dividend[2*DW-1] ^ i_divisor[DW-1];
            r_dz   <= (i_divisor == '0);
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end
    end

    // Sign and range are resolved from the magnitude during the final cycle.
    always_comb begin
        o_busy     = r_busy | r_fix;
        o_done     = r_fix;
        o_quotient = r_neg ? -r_q[DW-1:0] : r_q[DW-1:0];
        o_overflow = r_dz | (|r_q[2*DW-1:DW]) |
                     (r_neg ? (r_q[DW-1] & (|r_q[DW-2:0])) : r_q[DW-1]);
    end
endmodule

// File: rtl/ee354_det_bareiss.sv
// Fraction-free (Bareiss) determinant of an N x N signed integer matrix loaded row-major.
module ee354_det_bareiss
    import ee354_det_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned W  = 32,
    parameter int unsigned DW = 64
) (
    input logic           Clk,
    input logic           Reset,
    ee354_det_bareiss_if.slave bus
);
    localparam int unsigned IW = $clog2(N);
    localparam logic signed [DW-1:0] MIN_VAL = {1'b1, {(DW - 1){1'b0}}};

    state_e               r_state;
    logic signed [DW-1:0] r_m [N][N];
    logic [IW-1:0]        r_k;
    logic [IW-1:0]        r_i;
    logic [IW-1:0]        r_j;
    logic [IW-1:0]        r_r;
    logic [IW-1:0]        r_c;
    logic signed [DW-1:0] r_prev;
    logic signed [DW-1:0] r_det;
    logic                 r_neg;
    logic                 r_ovf;

    logic                   w_piv_found;
    logic [IW-1:0]          w_piv_row;
    logic signed [DW-1:0]   w_in_ext;
    logic signed [2*DW-1:0] w_akk, w_aij, w_aik, w_akj, w_num;
    logic                   w_div_start, w_div_busy, w_div_done, w_div_ovf;
    logic signed [DW-1:0]   w_quo;

    always_comb begin
        w_in_ext = {{(DW - W){bus.In_Data[W-1]}}, bus.In_Data};
        // Descending scan so the lowest qualifying row wins.
        w_piv_found = 1'b0;
        w_piv_row   = r_k;
        for (int i = N - 1; i >= 0; i--) begin
            if ((IW'(i) > r_k) && (r_m[i][r_k] != '0)) begin
                w_piv_found = 1'b1;
                w_piv_row   = IW'(i);
            end
        end
        w_akk = {{DW{r_m[r_k][r_k][DW-1]}}, r_m[r_k][r_k]};
        w_aij = {{DW{r_m[r_i][r_j][DW-1]}}, r_m[r_i][r_j]};
        w_aik = {{DW{r_m[r_i][r_k][DW-1]}}, r_m[r_i][r_k]};
        w_akj = {{DW{r_m[r_k][r_j][DW-1]}}, r_m[r_k][r_j]};
        w_num = w_akk * w_aij - w_aik * w_akj;
        w_div_start = (r_state == StElim) && !w_div_busy;
    end

    ee354_sdiv #(
        .DW(DW)
    ) u_sdiv (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_start   (w_div_start),
        .i_dividend(w_num),
        .i_divisor (r_prev),
        .o_busy    (w_div_busy),
        .o_done    (w_div_done),
        .o_quotient(w_quo),
        .o_overflow(w_div_ovf)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= StI;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_m[r][c] <= '0;
                end
            end
            r_k    <= '0;
            r_i    <= '0;
            r_j    <= '0;
            r_r    <= '0;
            r_c    <= '0;
            r_prev <= '0;
            r_det  <= '0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            unique case (r_state)
                StI: begin
                    if (bus.Start) begin
                        r_state <= StLoad;
                        r_ovf   <= 1'b0;
                        r_neg   <= 1'b0;
                        r_prev  <= DW'(1);
                        r_k     <= '0;
                        r_r     <= '0;
                        r_c     <= '0;
                    end
                end
                StLoad: begin
                    if (bus.In_Valid) begin
                        r_m[r_r][r_c] <= w_in_ext;
                        if (r_c == IW'(N - 1)) begin
                            r_c <= '0;
                            if (r_r == IW'(N - 1)) r_state <= StPivot;
                            else                   r_r     <= r_r + 1'b1;
                        end else begin
                            r_c <= r_c + 1'b1;
                        end
                    end
                end
                StPivot: begin
                    if (r_m[r_k][r_k] != '0) begin
                        r_i     <= r_k + 1'b1;
                        r_j     <= r_k + 1'b1;
                        r_state <= StElim;
                    end else if (w_piv_found) begin
                        for (int c = 0; c < N; c++) begin
                            r_m[r_k][c]       <= r_m[w_piv_row][c];
                            r_m[w_piv_row][c] <= r_m[r_k][c];
                        end
                        r_neg <= ~r_neg;
                    end else begin
                        r_det   <= '0;
                        r_state <= StDone;
                    end
                end
                StElim: begin
                    if (!w_div_busy) r_state <= StDiv;
                end
                StDiv: begin
                    if (w_div_done) begin
                        r_m[r_i][r_j] <= w_quo;
                        if (w_div_ovf) r_ovf <= 1'b1;
                        if (r_j != IW'(N - 1)) begin
                            r_j     <= r_j + 1'b1;
                            r_state <= StElim;
                        end else if (r_i != IW'(N - 1)) begin
                            r_i     <= r_i + 1'b1;
                            r_j     <= r_k + 1'b1;
                            r_state <= StElim;
                        end else begin
                            // The step's last quotient is always M[N-1][N-1].
                            r_prev <= r_m[r_k][r_k];
                            r_k    <= r_k + 1'b1;
                            if (r_k == IW'(N - 2)) begin
                                r_det   <= r_neg ? -w_quo : w_quo;
                                if (r_neg && (w_quo == MIN_VAL)) r_ovf <= 1'b1;
                                r_state <= StDone;
                            end else begin
                                r_state <= StPivot;
                            end
                        end
                    end
                end
                StDone: begin
                    if (bus.Ack) r_state <= StI;
                end
                default: r_state <= StI;
            endcase
        end
    end

    always_comb begin
        bus.q_I      = r_state[0];
        bus.q_Load   = r_state[1];
        bus.In_Ready = r_state[1];
        bus.q_Comp   = |r_state[4:2];
        bus.q_Done   = r_state[5];
        bus.Det      = r_det;
        bus.Overflow = r_ovf;
    end
endmodule

// File: tb/tb_ee354_det_bareiss.sv
// Scoreboard bench: three engines (N=8, 3, 4) share clock and reset; a monitor checks results.
module tb_ee354_det_bareiss;
    localparam int unsigned W  = 32;
    localparam int unsigned DW = 64;

    typedef struct packed {
        int                   dut;
        logic signed [DW-1:0] det;
        logic                 ovf;
        logic                 chk_det;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic                 start_s [3];
    logic                 ack_s   [3];
    logic                 vld_s   [3];
    logic signed [W-1:0]  dat_s   [3];
    logic                 done_w  [3];
    logic                 rdy_w   [3];
    logic                 idle_w  [3];
    logic                 comp_w  [3];
    logic                 ovf_w   [3];
    logic signed [DW-1:0] det_w   [3];

    ee354_det_bareiss_if #(.W(W), .DW(DW)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned NG = (g == 0) ? 8 : (g == 1) ? 3 : 4;
        ee354_det_bareiss #(.N(NG), .W(W), .DW(DW)) u_dut (
            .Clk  (Clk),
            .Reset(Reset),
            .bus  (bus[g])
        );
        assign bus[g].Start    = start_s[g];
        assign bus[g].Ack      = ack_s[g];
        assign bus[g].In_Valid = vld_s[g];
        assign bus[g].In_Data  = dat_s[g];
        assign done_w[g] = bus[g].q_Done;
        assign rdy_w[g]  = bus[g].In_Ready;
        assign idle_w[g] = bus[g].q_I;
        assign comp_w[g] = bus[g].q_Comp;
        assign ovf_w[g]  = bus[g].Overflow;
        assign det_w[g]  = bus[g].Det;
    end

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   t_start = 0;

    task automatic check_bit(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic check_word(input string name, input logic signed [DW-1:0] act,
                              input logic signed [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare every DONE cycle against the queue head; retire it on Ack.
    always begin
        exp_t e;
        @(negedge Clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (done_w[d] === 1'b1) begin
                if (sb.size() == 0 || sb[0].dut != d) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: dut %0d presented Det=%0d", d, det_w[d]);
                end else begin
                    e = sb[0];
                    if (e.chk_det) check_word("det", det_w[d], e.det);
                    check_bit("overflow", ovf_w[d], e.ovf);
                    if (ack_s[d]) e = sb.pop_front();
                end
            end
        end
    end

    task automatic kick(input int d);
        start_s[d] = 1'b1;
        @(negedge Clk);
        start_s[d] = 1'b0;
        t_start = int'(cyc);
        check_bit("load_entry_ready", rdy_w[d], 1'b1);
    endtask

    task automatic load(input int d, input int mat[$]);
        for (int e = 0; e < mat.size(); e++) begin
            vld_s[d] = 1'b1;
            dat_s[d] = mat[e];
            @(negedge Clk);
        end
        vld_s[d] = 1'b0;
        dat_s[d] = '0;
    endtask

    task automatic wait_done(input int d, output int lat, output bit ok);
        ok  = 1'b0;
        lat = -1;
        for (int c = 0; c < 20000 && !ok; c++) begin
            @(negedge Clk);
            if (done_w[d] === 1'b1) begin
                ok  = 1'b1;
                lat = int'(cyc) - t_start;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL done_timeout: dut %0d got no q_Done, required within 20000 cycles", d);
            void'(sb.pop_front());
        end
    endtask

    task automatic acknowledge(input int d);
        ack_s[d] = 1'b1;
        @(negedge Clk);
        ack_s[d] = 1'b0;
        check_bit("idle_after_ack", idle_w[d], 1'b1);
    endtask

    task automatic run(input int d, input int mat[$], input logic signed [DW-1:0] det,
                       input logic ovf, input logic chk, output int lat);
        bit ok;
        sb.push_back('{dut: d, det: det, ovf: ovf, chk_det: chk});
        kick(d);
        load(d, mat);
        wait_done(d, lat, ok);
        if (ok) acknowledge(d);
    endtask

    function automatic void diag8(output int mat[$], input int v);
        mat = {};
        for (int e = 0; e < 64; e++) mat.push_back((e % 9 == 0) ? v : 0);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mat[$];
        int lat;
        bit ok;
        Reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            ack_s[d]   = 1'b0;
            vld_s[d]   = 1'b0;
            dat_s[d]   = '0;
        end
        repeat (3) @(negedge Clk);
        for (int d = 0; d < 3; d++) begin
            check_bit("reset_q_I", idle_w[d], 1'b1);
            check_bit("reset_in_ready", rdy_w[d], 1'b0);
            check_bit("reset_overflow", ovf_w[d], 1'b0);
            check_word("reset_det", det_w[d], '0);
        end
        Reset = 1'b0;
        @(negedge Clk);

        diag8(mat, 1);
        run(0, mat, 64'sd1, 1'b0, 1'b1, lat);

        // Result held across a long Ack-low window with stray Start pulses.
        sb.push_back('{dut: 1, det: -64'sd306, ovf: 1'b0, chk_det: 1'b1});
        kick(1);
        load(1, '{6, 1, 1, 4, -2, 5, 2, 8, 7});
        wait_done(1, lat, ok);
        if (ok) begin
            for (int c = 0; c < 10; c++) begin
                start_s[1] = (c % 2 == 0);
                @(negedge Clk);
                check_bit("done_held", done_w[1], 1'b1);
            end
            start_s[1] = 1'b1;
            ack_s[1]   = 1'b1;
            @(negedge Clk);
            start_s[1] = 1'b0;
            ack_s[1]   = 1'b0;
            check_bit("ack_with_start_idle", idle_w[1], 1'b1);
            check_bit("ack_with_start_no_load", rdy_w[1], 1'b0);
            @(negedge Clk);
            check_bit("stays_idle", idle_w[1], 1'b1);
        end

        run(1, '{2, -3, 1, 4, 0, -5, -1, 2, 3}, 64'sd49, 1'b0, 1'b1, lat);
        run(1, '{0, 1, 0, 1, 0, 0, 0, 0, 1}, -64'sd1, 1'b0, 1'b1, lat);

        run(2, '{1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1}, 64'sd0, 1'b0, 1'b1, lat);
        total++;
        if (lat < 0 || lat > 1712) begin
            bad++;
            $display("FAIL n4_singular_latency: got %0d cycles, required at most 1712", lat);
        end

        diag8(mat, 2147483647);
        run(0, mat, 64'sd0, 1'b1, 1'b0, lat);

        // Abort a second run while the divider is mid-operation.
        kick(0);
        load(0, mat);
        repeat (40) @(negedge Clk);
        check_bit("mid_div_comp", comp_w[0], 1'b1);
        Reset = 1'b1;
        @(negedge Clk);
        check_bit("abort_q_I", idle_w[0], 1'b1);
        check_bit("abort_q_Comp", comp_w[0], 1'b0);
        check_word("abort_det", det_w[0], '0);
        check_bit("abort_overflow", ovf_w[0], 1'b0);
        Reset = 1'b0;
        @(negedge Clk);

        diag8(mat, 1);
        run(0, mat, 64'sd1, 1'b0, 1'b1, lat);

        @(negedge Clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drained: got %0d pending results, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
